// File: rtl/scoreboard_register_file.sv
// rtl/scoreboard_register_file.sv - register file with write bypass, busy scoreboard and PC slot
// Two write ports (wr1 wins), combinational read ports, per-register pending-producer tracking.
module scoreboard_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int NUM_READ   = 3,
   parameter int PC_INDEX   = 15,
   localparam int AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_READ*AW-1:0]     rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_READ-1:0]        rd_busy,
   input  logic                       wr0_en,
   input  logic [AW-1:0]              wr0_addr,
   input  logic [DATA_WIDTH-1:0]      wr0_data,
   input  logic                       wr1_en,
   input  logic [AW-1:0]              wr1_addr,
   input  logic [DATA_WIDTH-1:0]      wr1_data,
   input  logic [DATA_WIDTH-1:0]      pc_value,
   input  logic                       issue_en,
   input  logic [AW-1:0]              issue_addr,
   input  logic                       flush,
   output logic [NUM_REGS-1:0]        busy_vec,
   output logic                       any_busy
);

   localparam logic [AW:0]   NREGS_W = (AW+1)'(NUM_REGS);
   localparam logic [AW-1:0] PC_A    = AW'(PC_INDEX);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_q;

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return {1'b0, a} < NREGS_W;
   endfunction

   // The PC slot and out-of-range addresses are never written.
   logic wr0_store, wr1_store;
   assign wr0_store = wr0_en && addr_ok(wr0_addr) && (wr0_addr != PC_A);
   assign wr1_store = wr1_en && addr_ok(wr1_addr) && (wr1_addr != PC_A);

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (wr0_store) regs[wr0_addr] <= wr0_data;
         if (wr1_store) regs[wr1_addr] <= wr1_data;
      end
   end

   // Issue outranks a same-cycle writeback: the issuing instruction is the newer producer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (i == PC_INDEX || flush)
               busy_q[i] <= 1'b0;
            else if (issue_en && issue_addr == AW'(i))
               busy_q[i] <= 1'b1;
            else if ((wr0_en && wr0_addr == AW'(i)) || (wr1_en && wr1_addr == AW'(i)))
               busy_q[i] <= 1'b0;
         end
      end
   end

   assign busy_vec = busy_q;
   assign any_busy = |busy_q;

   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [AW-1:0] a;
      logic          ok, is_pc, hit1, hit0;
      assign a     = rd_addr[k*AW +: AW];
      assign ok    = addr_ok(a);
      assign is_pc = (a == PC_A);
      assign hit1  = wr1_en && (wr1_addr == a);
      assign hit0  = wr0_en && (wr0_addr == a);
      assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
         !ok   ? '0       :
         is_pc ? pc_value :
         hit1  ? wr1_data :
         hit0  ? wr0_data : regs[a];
      // A bypassed value is already in hand, so the port is not reported busy.
      assign rd_busy[k] = ok && !is_pc && busy_q[a] && !hit1 && !hit0;
   end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb/tb_scoreboard_register_file.sv - directed self-checking bench for scoreboard_register_file
module tb_scoreboard_register_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] rd_addr;
   logic [95:0] rd_data;
   logic [2:0]  rd_busy;
   logic        wr0_en, wr1_en, issue_en, flush;
   logic [3:0]  wr0_addr, wr1_addr, issue_addr;
   logic [31:0] wr0_data, wr1_data, pc_value;
   logic [15:0] busy_vec;
   logic        any_busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   scoreboard_register_file dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .pc_value(pc_value), .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
      .busy_vec(busy_vec), .any_busy(any_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr0_en = 0; wr1_en = 0; issue_en = 0; flush = 0;
      wr0_addr = 0; wr1_addr = 0; issue_addr = 0;
      wr0_data = 0; wr1_data = 0;
   endtask

   task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
      rd_addr = {a2, a1, a0};
   endtask

   task automatic test_reset();
      reset = 0; idle(); pc_value = 32'h1000; set_rd(0, 15, 0);
      step(); step();
      #2;
      vectors++;
      if (busy_vec !== 16'h0) begin
         miscompares++; $display("FAIL reset_busy_vec got=%h exp=0000", busy_vec);
      end
      vectors++;
      if (any_busy !== 1'b0) begin
         miscompares++; $display("FAIL reset_any_busy got=%b exp=0", any_busy);
      end
      vectors++;
      if (rd_data[63:32] !== 32'h1000) begin
         miscompares++; $display("FAIL reset_pc_read got=%h exp=00001000", rd_data[63:32]);
      end
      for (int r = 0; r < 15; r++) begin
         set_rd(4'(r), 15, 0);
         #1;
         vectors++;
         if (rd_data[31:0] !== 32'h0) begin
            miscompares++; $display("FAIL reset_reg%0d got=%h exp=00000000", r, rd_data[31:0]);
         end
      end
      reset = 1;
      step();
   endtask

   task automatic test_write_bypass();
      idle(); set_rd(3, 15, 0);
      wr0_en = 1; wr0_addr = 3; wr0_data = 32'hDEADBEEF;
      #2;
      vectors++;
      if (rd_data[31:0] !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL bypass_r3 got=%h exp=deadbeef", rd_data[31:0]);
      end
      step(); idle(); #2;
      vectors++;
      if (rd_data[31:0] !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL stored_r3 got=%h exp=deadbeef", rd_data[31:0]);
      end
      wr0_en = 1; wr0_addr = 15; wr0_data = 32'h5;
      #2;
      vectors++;
      if (rd_data[63:32] !== 32'h1000) begin
         miscompares++; $display("FAIL pc_no_bypass got=%h exp=00001000", rd_data[63:32]);
      end
      step(); idle(); #2;
      vectors++;
      if (rd_data[63:32] !== 32'h1000) begin
         miscompares++; $display("FAIL pc_not_stored got=%h exp=00001000", rd_data[63:32]);
      end
   endtask

   task automatic test_priority();
      idle(); set_rd(4, 0, 0);
      wr0_en = 1; wr0_addr = 4; wr0_data = 32'h11;
      wr1_en = 1; wr1_addr = 4; wr1_data = 32'h22;
      #2;
      vectors++;
      if (rd_data[31:0] !== 32'h22) begin
         miscompares++; $display("FAIL prio_bypass got=%h exp=00000022", rd_data[31:0]);
      end
      step(); idle(); #2;
      vectors++;
      if (rd_data[31:0] !== 32'h22) begin
         miscompares++; $display("FAIL prio_stored got=%h exp=00000022", rd_data[31:0]);
      end
   endtask

   task automatic test_scoreboard();
      idle(); set_rd(5, 6, 15);
      issue_en = 1; issue_addr = 5;
      step(); idle(); #2;
      vectors++;
      if (busy_vec !== 16'h0020) begin
         miscompares++; $display("FAIL issue_r5_vec got=%h exp=0020", busy_vec);
      end
      vectors++;
      if (rd_busy !== 3'b001 || any_busy !== 1'b1) begin
         miscompares++; $display("FAIL issue_r5_rd_busy got=%b/%b exp=001/1", rd_busy, any_busy);
      end
      wr1_en = 1; wr1_addr = 5; wr1_data = 32'h7;
      #2;
      vectors++;
      if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h7) begin
         miscompares++; $display("FAIL wb_r5_same got=%b/%h exp=0/00000007", rd_busy[0], rd_data[31:0]);
      end
      step(); idle(); #2;
      vectors++;
      if (busy_vec !== 16'h0) begin
         miscompares++; $display("FAIL wb_r5_clear got=%h exp=0000", busy_vec);
      end
      issue_en = 1; issue_addr = 6; wr0_en = 1; wr0_addr = 6; wr0_data = 32'h66;
      step(); idle(); #2;
      vectors++;
      if (busy_vec !== 16'h0040 || rd_busy !== 3'b010 || rd_data[63:32] !== 32'h66) begin
         miscompares++;
         $display("FAIL issue_beats_wb got=%h/%b/%h exp=0040/010/00000066", busy_vec, rd_busy, rd_data[63:32]);
      end
      wr0_en = 1; wr0_addr = 6; wr0_data = 32'h67; issue_en = 1; issue_addr = 15;
      step(); idle(); #2;
      vectors++;
      if (busy_vec !== 16'h0 || rd_busy !== 3'b000) begin
         miscompares++; $display("FAIL pc_issue_ignored got=%h/%b exp=0000/000", busy_vec, rd_busy);
      end
   endtask

   task automatic test_flush();
      idle(); set_rd(10, 7, 9);
      issue_en = 1; issue_addr = 1; step();
      issue_addr = 2; step();
      issue_addr = 9; step();
      idle(); #2;
      vectors++;
      if (busy_vec !== 16'h0206 || any_busy !== 1'b1 || rd_busy !== 3'b100) begin
         miscompares++; $display("FAIL pre_flush got=%h/%b/%b exp=0206/1/100", busy_vec, any_busy, rd_busy);
      end
      flush = 1; issue_en = 1; issue_addr = 7; wr0_en = 1; wr0_addr = 10; wr0_data = 32'hAB;
      step(); idle(); #2;
      vectors++;
      if (busy_vec !== 16'h0 || any_busy !== 1'b0) begin
         miscompares++; $display("FAIL flush got=%h/%b exp=0000/0", busy_vec, any_busy);
      end
      vectors++;
      if (rd_data[31:0] !== 32'hAB) begin
         miscompares++; $display("FAIL flush_write_commit got=%h exp=000000ab", rd_data[31:0]);
      end
   endtask

   task automatic test_back_to_back();
      idle(); set_rd(0, 1, 2);
      wr0_en = 1; wr0_addr = 0; wr0_data = 32'hA0; step();
      wr0_addr = 1; wr0_data = 32'hA1; wr1_en = 1; wr1_addr = 2; wr1_data = 32'hA2;
      #2;
      vectors++;
      if (rd_data !== {32'hA2, 32'hA1, 32'hA0}) begin
         miscompares++; $display("FAIL b2b_reads got=%h exp=000000a2000000a1000000a0", rd_data);
      end
      step(); idle(); #2;
      vectors++;
      if (rd_data !== {32'hA2, 32'hA1, 32'hA0}) begin
         miscompares++; $display("FAIL b2b_stored got=%h exp=000000a2000000a1000000a0", rd_data);
      end
   endtask

   task automatic test_reset_mid();
      idle(); set_rd(8, 3, 4);
      wr0_en = 1; wr0_addr = 8; wr0_data = 32'h55; issue_en = 1; issue_addr = 3;
      step(); idle(); #2;
      vectors++;
      if (rd_data[31:0] !== 32'h55 || busy_vec !== 16'h0008) begin
         miscompares++; $display("FAIL pre_reset got=%h/%h exp=00000055/0008", rd_data[31:0], busy_vec);
      end
      reset = 0; wr0_en = 1; wr0_addr = 8; wr0_data = 32'h9; issue_en = 1; issue_addr = 8;
      step(); idle(); reset = 1; #2;
      vectors++;
      if (rd_data[31:0] !== 32'h0 || busy_vec !== 16'h0 || any_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid got=%h/%h/%b exp=00000000/0000/0", rd_data[31:0], busy_vec, any_busy);
      end
      vectors++;
      if (rd_data[95:32] !== 64'h0) begin
         miscompares++; $display("FAIL reset_mid_others got=%h exp=0", rd_data[95:32]);
      end
   endtask

   initial begin
      test_reset();
      test_write_bypass();
      test_priority();
      test_scoreboard();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
